// File: rtl/memn2n_emb_decode.sv
// MemN2N answer decoder: scores an embedding against every weight row and returns the argmax row/score.
// Optional per-row score stream enabled by defining MEMN2N_DECODE_SCORE_OUT_EN.
//
//  state   | meaning
//  IDLE    | waiting for start, host may write weight rows
//  RUN     | issuing row addresses 0..DIM_VOCAB-1
//  DRAIN   | 3 cycles flushing the S1..S3 pipeline
//  DONE    | one-cycle done pulse, ans_* valid
module memn2n_emb_decode #(
   parameter int DIM_VOCAB  = 20,
   parameter int BW_DIM_EMB = 3,
   parameter int BW_DATA    = 32,
   parameter int IWL        = 16,
   parameter int BW_ADDR    = 5
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 start,
   input  logic [BW_DATA*(1<<BW_DIM_EMB)-1:0]   emb_in,
   input  logic                                 w_we,
   input  logic [BW_ADDR-1:0]                   w_addr,
   input  logic [BW_DATA*(1<<BW_DIM_EMB)-1:0]   w_data,
   output logic                                 busy,
   output logic                                 done,
   output logic [BW_ADDR-1:0]                   ans_idx,
   output logic [BW_DATA-1:0]                   ans_score
`ifdef MEMN2N_DECODE_SCORE_OUT_EN
   ,
   output logic                                 score_valid,
   output logic [BW_ADDR-1:0]                   score_idx,
   output logic [BW_DATA-1:0]                   score
`endif
);

   localparam int DIM_EMB = 1 << BW_DIM_EMB;
   localparam int FRAC    = BW_DATA - IWL;
   localparam int BW_ROW  = BW_DATA * DIM_EMB;
   localparam int BW_SUM  = BW_DATA + BW_DIM_EMB;
   localparam logic signed [BW_DATA-1:0] MAX_P = {1'b0, {(BW_DATA-1){1'b1}}};
   localparam logic signed [BW_DATA-1:0] MIN_N = {1'b1, {(BW_DATA-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t                      r_state, w_next;
   logic [1:0]                  r_drain_cnt;
   logic [BW_ROW-1:0]           r_mem [DIM_VOCAB];
   logic [BW_ROW-1:0]           r_ram_q;
   logic [BW_ROW-1:0]           r_emb;
   logic [BW_ADDR-1:0]          r_rd_addr;
   logic                        r_v1, r_v2, r_v3;
   logic [BW_ADDR-1:0]          r_idx1, r_idx2, r_idx3;
   logic signed [BW_DATA-1:0]   r_prod [DIM_EMB];
   logic signed [BW_DATA-1:0]   w_prod [DIM_EMB];
   logic signed [BW_DATA-1:0]   w_sum_sat;
   logic signed [BW_DATA-1:0]   r_sum3;
   logic signed [BW_DATA-1:0]   r_max;
   logic [BW_ADDR-1:0]          r_max_idx;
   logic [BW_ADDR-1:0]          r_ans_idx;
   logic [BW_DATA-1:0]          r_ans_score;
   logic                        w_gt;
   logic                        w_wr_ok;
   logic                        w_last_drain;

   function automatic logic signed [BW_DATA-1:0] mul_sat(input logic signed [BW_DATA-1:0] a,
                                                         input logic signed [BW_DATA-1:0] b);
      logic signed [2*BW_DATA-1:0] p;
      p = ((2*BW_DATA)'(a) * (2*BW_DATA)'(b)) >>> FRAC;
      if (p > (2*BW_DATA)'(MAX_P))      return MAX_P;
      else if (p < (2*BW_DATA)'(MIN_N)) return MIN_N;
      else                              return p[BW_DATA-1:0];
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = S_RUN;
         S_RUN:   if (r_rd_addr == BW_ADDR'(DIM_VOCAB-1)) w_next = S_DRAIN;
         S_DRAIN: if (r_drain_cnt == 2'd0) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (r_state == S_RUN) || (r_state == S_DRAIN);
      done = (r_state == S_DONE);
   end

   // Weight RAM: no reset, writes only accepted while idle and in range.
   assign w_wr_ok = w_we && (r_state == S_IDLE) &&
                    ({1'b0, w_addr} < (BW_ADDR+1)'(DIM_VOCAB));

   always_ff @(posedge clk) begin
      if (w_wr_ok) r_mem[w_addr] <= w_data;
      r_ram_q <= r_mem[r_rd_addr];
   end

   always_comb begin
      for (int l = 0; l < DIM_EMB; l++)
         w_prod[l] = mul_sat(r_ram_q[l*BW_DATA +: BW_DATA], r_emb[l*BW_DATA +: BW_DATA]);
   end

   always_comb begin
      logic signed [BW_SUM-1:0] acc;
      acc = '0;
      for (int l = 0; l < DIM_EMB; l++) acc = acc + BW_SUM'(r_prod[l]);
      if (acc > BW_SUM'(MAX_P))      w_sum_sat = MAX_P;
      else if (acc < BW_SUM'(MIN_N)) w_sum_sat = MIN_N;
      else                           w_sum_sat = acc[BW_DATA-1:0];
   end

   // Strict compare so ties keep the lowest index.
   assign w_gt         = r_v3 && (r_sum3 > r_max);
   assign w_last_drain = (r_state == S_DRAIN) && (r_drain_cnt == 2'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_emb       <= '0;
         r_rd_addr   <= '0;
         r_drain_cnt <= '0;
         r_v1        <= 1'b0;
         r_v2        <= 1'b0;
         r_v3        <= 1'b0;
         r_idx1      <= '0;
         r_idx2      <= '0;
         r_idx3      <= '0;
         for (int l = 0; l < DIM_EMB; l++) r_prod[l] <= '0;
         r_sum3      <= '0;
         r_max       <= MIN_N;
         r_max_idx   <= '0;
         r_ans_idx   <= '0;
         r_ans_score <= '0;
      end else begin
         r_v1   <= (r_state == S_RUN);
         r_idx1 <= r_rd_addr;
         r_v2   <= r_v1;
         r_idx2 <= r_idx1;
         for (int l = 0; l < DIM_EMB; l++) r_prod[l] <= w_prod[l];
         r_v3   <= r_v2;
         r_idx3 <= r_idx2;
         r_sum3 <= w_sum_sat;
         if (w_gt) begin
            r_max     <= r_sum3;
            r_max_idx <= r_idx3;
         end
         case (r_state)
            S_IDLE: if (start) begin
               r_emb     <= emb_in;
               r_rd_addr <= '0;
               r_max     <= MIN_N;
               r_max_idx <= '0;
            end
            S_RUN: begin
               r_rd_addr <= r_rd_addr + 1'b1;
               if (w_next == S_DRAIN) r_drain_cnt <= 2'd2;
            end
            S_DRAIN: r_drain_cnt <= r_drain_cnt - 1'b1;
            default: ;
         endcase
         // Last row reaches S3 in the final drain cycle; fold it in directly.
         if (w_last_drain) begin
            r_ans_idx   <= w_gt ? r_idx3 : r_max_idx;
            r_ans_score <= w_gt ? r_sum3 : r_max;
         end
      end
   end

   assign ans_idx   = r_ans_idx;
   assign ans_score = r_ans_score;

`ifdef MEMN2N_DECODE_SCORE_OUT_EN
   assign score_valid = r_v3;
   assign score_idx   = r_idx3;
   assign score       = r_sum3;
`endif

endmodule

// File: tb/tb_memn2n_emb_decode.sv
// Directed-vector bench for memn2n_emb_decode: argmax, ties, saturation, reset abort, busy-write guard.
// Checks the per-row score stream when MEMN2N_DECODE_SCORE_OUT_EN is defined.
module tb_memn2n_emb_decode;

   localparam int DIM_VOCAB = 20;
   localparam int BW_DATA   = 32;
   localparam int BW_ADDR   = 5;
   localparam int BW_ROW    = 256;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                start;
   logic [BW_ROW-1:0]   emb_in;
   logic                w_we;
   logic [BW_ADDR-1:0]  w_addr;
   logic [BW_ROW-1:0]   w_data;
   logic                busy;
   logic                done;
   logic [BW_ADDR-1:0]  ans_idx;
   logic [BW_DATA-1:0]  ans_score;
`ifdef MEMN2N_DECODE_SCORE_OUT_EN
   logic                score_valid;
   logic [BW_ADDR-1:0]  score_idx;
   logic [BW_DATA-1:0]  score;
`endif

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   memn2n_emb_decode dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .emb_in    (emb_in),
      .w_we      (w_we),
      .w_addr    (w_addr),
      .w_data    (w_data),
      .busy      (busy),
      .done      (done),
      .ans_idx   (ans_idx),
      .ans_score (ans_score)
`ifdef MEMN2N_DECODE_SCORE_OUT_EN
      ,
      .score_valid (score_valid),
      .score_idx   (score_idx),
      .score       (score)
`endif
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [BW_ROW-1:0] rep(input logic [31:0] v);
      return {8{v}};
   endfunction

   task automatic wr_row(input int a, input logic [BW_ROW-1:0] d);
      w_we   = 1'b1;
      w_addr = a[BW_ADDR-1:0];
      w_data = d;
      @(negedge clk);
      w_we   = 1'b0;
   endtask

   task automatic load_all(input logic [31:0] v);
      for (int i = 0; i < DIM_VOCAB; i++) wr_row(i, rep(v));
   endtask

   // Called at a negedge; returns at the negedge of the done cycle.
   task automatic run_decode(input logic [BW_ROW-1:0] emb, input logic [4:0] exp_idx,
                             input logic [31:0] exp_score, input string tag, input bit ramp);
      int cyc, busy_bad, ns;
      emb_in = emb;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      w_we   = 1'b0;
      cyc = 1; busy_bad = 0; ns = 0;
      while (!done && cyc < 100) begin
         if (!busy) busy_bad++;
`ifdef MEMN2N_DECODE_SCORE_OUT_EN
         if (score_valid) begin
            if (ramp) begin
               check({tag, "_sidx"}, 64'(score_idx), 64'(ns));
               check({tag, "_sval"}, 64'(score), 64'(ns * 32'h0008_0000));
            end
            ns++;
         end
`endif
         @(negedge clk);
         cyc++;
      end
      check({tag, "_lat"}, 64'(cyc), 64'(DIM_VOCAB + 4));
      check({tag, "_busy_run"}, 64'(busy_bad), 64'd0);
      check({tag, "_busy_done"}, 64'(busy), 64'd0);
      check({tag, "_idx"}, 64'(ans_idx), 64'(exp_idx));
      check({tag, "_score"}, 64'(ans_score), 64'(exp_score));
`ifdef MEMN2N_DECODE_SCORE_OUT_EN
      check({tag, "_npulse"}, 64'(ns), 64'(DIM_VOCAB));
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int seen;
      rst_n = 1'b0; start = 1'b0; emb_in = '0; w_we = 1'b0; w_addr = '0; w_data = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_idx", 64'(ans_idx), 64'd0);
      check("rst_score", 64'(ans_score), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Row i = i.0 in every lane, emb = 1.0: score = 8*i
      for (int i = 0; i < DIM_VOCAB; i++) wr_row(i, rep(32'(i) << 16));
      run_decode(rep(32'h0001_0000), 5'd19, 32'h0098_0000, "ramp", 1'b1);
      @(negedge clk);
      run_decode(rep(32'h0001_0000), 5'd19, 32'h0098_0000, "b2b", 1'b1);

      // Abort in RUN at cycle 5
      @(negedge clk);
      emb_in = rep(32'h0001_0000);
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      repeat (4) @(negedge clk);
      check("abort_busy_pre", 64'(busy), 64'd1);
      rst_n = 1'b0;
      #1;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      check("abort_idx", 64'(ans_idx), 64'd0);
      check("abort_score", 64'(ans_score), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (30) begin
         @(negedge clk);
         if (done) seen++;
      end
      check("abort_no_done", 64'(seen), 64'd0);
      run_decode(rep(32'h0001_0000), 5'd19, 32'h0098_0000, "after_abort", 1'b1);
      @(negedge clk);

      // Tie between rows 3 and 7 at 2.0 * 8 = 16.0
      load_all(32'h0);
      wr_row(3, rep(32'h0002_0000));
      wr_row(7, rep(32'h0002_0000));
      run_decode(rep(32'h0001_0000), 5'd3, 32'h0010_0000, "tie", 1'b0);
      @(negedge clk);

      // Write row 7 in the same cycle as start: visible to this decode
      load_all(32'h0);
      w_we = 1'b1; w_addr = 5'd7; w_data = rep(32'h0003_0000);
      run_decode(rep(32'h0001_0000), 5'd7, 32'h0018_0000, "same_cyc_wr", 1'b0);
      @(negedge clk);

      // Product and sum saturation
      load_all(32'h0);
      wr_row(5, rep(32'h7FFF_0000));
      run_decode(rep(32'h7FFF_0000), 5'd5, 32'h7FFF_FFFF, "sat", 1'b0);
      @(negedge clk);

      // All -1.0, plus an attempted write to row 0 while busy
      load_all(32'hFFFF_0000);
      fork
         run_decode(rep(32'h0001_0000), 5'd0, 32'hFFF8_0000, "neg", 1'b0);
         begin
            repeat (3) @(negedge clk);
            w_we = 1'b1; w_addr = 5'd0; w_data = rep(32'h0010_0000);
            @(negedge clk);
            w_we = 1'b0;
         end
      join
      @(negedge clk);
      run_decode(rep(32'h0001_0000), 5'd0, 32'hFFF8_0000, "busy_wr_ignored", 1'b0);
      @(negedge clk);

      // Every score saturates to the most-negative value
      for (int i = 0; i < DIM_VOCAB; i++) wr_row(i, {224'd0, 32'h8000_0000});
      run_decode(rep(32'h7FFF_0000), 5'd0, 32'h8000_0000, "all_min", 1'b0);
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/memn2n_emb_decode.md
Name: memn2n_emb_decode

Overview:
- Output-side counterpart of the bag-of-words embedding accumulator: takes a DIM_EMB-wide embedding vector and scores it against every vocabulary row of a decode weight matrix.
- Scores are score[i] = dot(W[i], emb). The block tracks the argmax over all rows and returns the answer word index and its score.
- Sits after the memory hop (u+o) in the MemN2N datapath and feeds answer selection. It also owns a host write port for loading W.

Parameters:
- DIM_VOCAB, 20, number of vocabulary rows (must be ≤ 2^BW_ADDR).
- BW_DIM_EMB, 3, log2 of embedding width; DIM_EMB = 1<<BW_DIM_EMB.
- BW_DATA, 32, fixed-point word width (WL).
- IWL, 16, integer bits incl. sign; FRAC = BW_DATA-IWL.
- BW_ADDR, 5, row address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  single-cycle pulse, begins decode of emb_in
- emb_in  in  BW_DATA*DIM_EMB  embedding vector, lane i at [(i+1)*BW_DATA-1 -: BW_DATA], sampled on start
- w_we  in  1  weight row write strobe
- w_addr  in  BW_ADDR  weight row address
- w_data  in  BW_DATA*DIM_EMB  weight row data, same lane packing
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse, result valid
- ans_idx  out  BW_ADDR  argmax row index, held until next start
- ans_score  out  BW_DATA  score of ans_idx, held until next start

Behaviour:
- Reset: FSM=IDLE, busy=0, done=0, ans_idx=0, ans_score=0, emb buffer=0, all pipeline valids=0. Weight RAM contents are not reset.
- Weight RAM: DIM_VOCAB rows × BW_DATA*DIM_EMB bits, synchronous read with 1-cycle latency.
  - Write when w_we=1 and FSM=IDLE.
  - w_we while busy is ignored; no write occurs.
  - w_addr ≥ DIM_VOCAB is ignored.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: on start, latch emb_in, set rd_addr=0, max=most-negative (0x8000_0000), max_idx=0; go to RUN.
  - RUN: issue rd_addr each cycle, 0..DIM_VOCAB-1. After issuing DIM_VOCAB-1, go to DRAIN.
  - DRAIN: 3 cycles, flushing the pipeline. Then go to DONE.
  - DONE: done=1 for one cycle, ans_* updated, then IDLE.
  - start outside IDLE is ignored.
- Pipeline per row:
  - S0: address issued.
  - S1: RAM row valid; DIM_EMB signed products computed; each product is 2*BW_DATA bits, arithmetic right shift by FRAC, saturated to BW_DATA; registered.
  - S2: adder tree sum at BW_DATA+BW_DIM_EMB bits, saturated to BW_DATA; registered with row index.
  - S3: compare; if sum > max (signed, strict), update max and max_idx.
- Ties keep the lowest index.
- Latency: done asserts exactly DIM_VOCAB+4 cycles after the start cycle. busy=1 for the DIM_VOCAB+3 cycles before done and is low during the done cycle.
- Saturation: positive overflow → 0x7FFF_FFFF; negative overflow → 0x8000_0000.
- If all scores equal 0x8000_0000: ans_idx=0, ans_score=0x8000_0000.
- Reset asserted mid-decode: immediate return to IDLE; no done pulse; ans_* cleared to 0.
- start and w_we in the same IDLE cycle: both accepted. The write completes before S1 of any row, so the new row is visible to this decode.
- Back-to-back: start in the cycle after done is accepted.

Optional Feature:
- Macro MEMN2N_DECODE_SCORE_OUT_EN.
- Defined: adds outputs score_valid (1), score_idx (BW_ADDR), score (BW_DATA).
  - score_valid pulses in the S3 cycle of each row, carrying that row's saturated score.
  - Exactly DIM_VOCAB pulses per decode, in index order, for the downstream softmax/gradient path.
- Undefined: these ports and their registers are absent; argmax behaviour is identical.

Test Plan:
- Load W[i] lanes = i<<16 (i.0), emb lanes = 1.0 (0x0001_0000), start → done at cycle DIM_VOCAB+4; ans_idx=19, ans_score=0x0098_0000 (8×19.0=152.0).
- W[3]=W[7]=all 2.0, others 0, emb = 1.0 → ans_idx=3 (tie keeps lowest), ans_score=0x0010_0000.
- W[5] lanes = 0x7FFF_0000, emb lanes = 0x7FFF_0000, others 0 → product saturates; ans_idx=5, ans_score=0x7FFF_FFFF.
- All W = -1.0, emb = 1.0 → ans_idx=0, ans_score=0xFFF8_0000 (-8.0). w_we during busy to row 0 leaves W[0] unchanged; verify with a second decode.
- Assert rst_n mid-RUN (cycle 5) → busy=0 and ans_*=0 immediately, no done. A following start runs a full decode correctly.
- With MEMN2N_DECODE_SCORE_OUT_EN, first test → 20 score_valid pulses; score_idx 0..19; score=i×0x0008_0000.
